// File: rtl/filter_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_ctl_pkg
// Purpose  : Shared types for the filter control snapshot reader.
// Revision : 1.0
// ============================================================================
package filter_ctl_pkg;

    localparam int FILTER_CTL_W = 10;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] coef;
    } filter_ctl_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } reader_state_t;

    // Index width for a dimension of n entries, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_ctl_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : filter_ctl_reader_if
// Purpose  : Valid/ready entry stream carrying data plus row/col position.
// Revision : 1.0
// ============================================================================
interface filter_ctl_reader_if #(
    parameter int ROWS  = 2,
    parameter int COLS  = 3,
    parameter int OUT_W = 32
) ();

    localparam int ROW_W = filter_ctl_pkg::idx_w(ROWS);
    localparam int COL_W = filter_ctl_pkg::idx_w(COLS);

    logic             out_valid_o;
    logic             out_ready_i;
    logic [OUT_W-1:0] out_data_o;
    logic [ROW_W-1:0] out_row_o;
    logic [COL_W-1:0] out_col_o;
    logic             out_last_o;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_row_o,
        output out_col_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_row_o,
        input  out_col_o,
        input  out_last_o,
        output out_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/filter_ctl_idx_cnt.sv
`default_nettype none
// ============================================================================
// Module   : filter_ctl_idx_cnt
// Purpose  : Row-major row/column walker with wrap and last-entry detect.
// Revision : 1.0
// ============================================================================
module filter_ctl_idx_cnt
    import filter_ctl_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 3,
    parameter int ROW_W = idx_w(ROWS),
    parameter int COL_W = idx_w(COLS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_adv,
    output logic      [ROW_W-1:0] o_row,
    output logic      [COL_W-1:0] o_col,
    output logic                  o_last
);

    localparam logic [ROW_W-1:0] c_row_max = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] c_col_max = COL_W'(COLS - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_last;

    assign w_last = (r_row == c_row_max) && (r_col == c_col_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (r_col == c_col_max) begin
                r_col <= '0;
                r_row <= w_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/filter_ctl_reader.sv
`default_nettype none
// ============================================================================
// Module   : filter_ctl_reader
// Purpose  : Snapshots a 2D filter control array and streams it row-major.
// Revision : 1.0
// ============================================================================
module filter_ctl_reader
    import filter_ctl_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 3,
    parameter int OUT_W = 32
) (
    input  wire logic                               clk,
    input  wire logic                               rst_n,
    input  wire logic                               load_i,
    input  wire filter_ctl_t [ROWS-1:0][COLS-1:0]   cfg_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    filter_ctl_reader_if.master                     out_if
);

    localparam int ROW_W = idx_w(ROWS);
    localparam int COL_W = idx_w(COLS);

    reader_state_t                   r_state;
    reader_state_t                   w_state_nxt;
    filter_ctl_t [ROWS-1:0][COLS-1:0] r_snap;
    logic                            r_done;

    logic                    w_busy;
    logic                    w_capture;
    logic                    w_fire;
    logic                    w_final;
    logic [ROW_W-1:0]        w_row;
    logic [COL_W-1:0]        w_col;
    logic                    w_last_idx;
    filter_ctl_t             w_entry;
    logic [FILTER_CTL_W-1:0] w_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (load_i) w_state_nxt = STREAM;
            STREAM:  if (out_if.out_ready_i && w_last_idx) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // load_i is only honoured from IDLE, so a request during streaming is dropped.
    always_comb begin
        w_busy    = (r_state == STREAM);
        w_capture = (r_state == IDLE) && load_i;
        w_fire    = w_busy && out_if.out_ready_i;
        w_final   = w_fire && w_last_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (w_capture) begin
            r_snap <= cfg_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_final;
        end
    end

    filter_ctl_idx_cnt #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_idx_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_capture),
        .i_adv  (w_fire),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last_idx)
    );

    assign w_entry = r_snap[w_row][w_col];
    assign w_word  = w_busy ? {w_entry.mode, w_entry.coef} : '0;

    generate
        if (OUT_W > FILTER_CTL_W) begin : g_pad
            assign out_if.out_data_o = {{(OUT_W - FILTER_CTL_W){1'b0}}, w_word};
        end else begin : g_exact
            assign out_if.out_data_o = w_word;
        end
    endgenerate

    assign out_if.out_valid_o = w_busy;
    assign out_if.out_row_o   = w_busy ? w_row : '0;
    assign out_if.out_col_o   = w_busy ? w_col : '0;
    assign out_if.out_last_o  = w_busy && w_last_idx;
    assign busy_o             = w_busy;
    assign done_o             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_filter_ctl_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_ctl_reader
// Purpose  : Self-checking bench for filter_ctl_reader against a queue model.
// Revision : 1.0
// ============================================================================
module tb_filter_ctl_reader;

    localparam int ROWS  = 2;
    localparam int COLS  = 3;
    localparam int OUT_W = 32;
    localparam int N     = ROWS * COLS;
    localparam int CW    = N * 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_i;
    logic [CW-1:0] cfg_i;
    logic          busy_o;
    logic          done_o;

    filter_ctl_reader_if #(.ROWS(ROWS), .COLS(COLS), .OUT_W(OUT_W)) bus ();

    filter_ctl_reader #(.ROWS(ROWS), .COLS(COLS), .OUT_W(OUT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_i),
        .cfg_i  (cfg_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .out_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cfg;
        int            ready_mode;   // 0 always, 1 toggle, 2 random
        int            reload_beat;  // -1 none
        bit            change_after;
        int            exp_cycles;   // load-to-done cycles, 0 = unchecked
    } vec_t;

    typedef struct {
        logic [9:0] data;
        int         row;
        int         col;
        bit         last;
    } beat_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] entry(input logic [CW-1:0] cfg, input int r, input int c);
        return cfg[(r*COLS+c)*10 +: 10];
    endfunction

    task automatic check_beat(input beat_t b);
        check("valid", bus.out_valid_o, 1);
        check("busy", busy_o, 1);
        check("done_mid", done_o, 0);
        check("data", bus.out_data_o, {54'd0, b.data});
        check("row", bus.out_row_o, b.row);
        check("col", bus.out_col_o, b.col);
        check("last", bus.out_last_o, b.last);
    endtask

    task automatic run_snap(input vec_t v);
        beat_t q[$];
        int    cycles;
        int    beat;
        bit    rdy;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                q.push_back('{entry(v.cfg, r, c), r, c, (r == ROWS-1) && (c == COLS-1)});
        @(negedge clk);
        check("pre_valid", bus.out_valid_o, 0);
        check("pre_busy", busy_o, 0);
        load_i = 1'b1;
        cfg_i  = v.cfg;
        bus.out_ready_i = 1'b1;
        cycles = 0;
        beat   = 0;
        while (q.size() > 0 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            load_i = 1'b0;
            if (v.change_after) cfg_i = ~v.cfg;
            if (beat == v.reload_beat) begin
                load_i = 1'b1;
                cfg_i  = ~v.cfg ^ {CW{1'b1}} ^ 60'h2AA_5555_AAAA_5555;
            end
            check_beat(q[0]);
            case (v.ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2) == 1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready_i = rdy;
            if (rdy) begin
                void'(q.pop_front());
                beat++;
            end
        end
        check("stream_timeout", q.size(), 0);
        @(negedge clk);
        cycles++;
        load_i = 1'b0;
        check("end_valid", bus.out_valid_o, 0);
        check("end_done", done_o, 1);
        check("end_busy", busy_o, 0);
        check("end_data", bus.out_data_o, 0);
        if (v.exp_cycles > 0) check("done_latency", cycles, v.exp_cycles);
        @(negedge clk);
        check("done_pulse_width", done_o, 0);
        check("idle_valid", bus.out_valid_o, 0);
    endtask

    vec_t tbl[4];

    initial begin
        logic [CW-1:0] seq;
        logic [63:0]   rnd;
        vec_t          v;
        int            idx;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                seq[(r*COLS+c)*10 +: 10] = 10'(r*16 + c + 1);
        tbl[0] = '{{N{10'h3ff}}, 0, -1, 1'b0, N + 1};
        tbl[1] = '{seq, 1, -1, 1'b0, 0};
        tbl[2] = '{seq, 0, 3, 1'b0, N + 1};
        tbl[3] = '{60'h123_4567_89AB_CDEF, 2, -1, 1'b1, 0};

        rst_n = 1'b0;
        load_i = 1'b0;
        cfg_i = '0;
        bus.out_ready_i = 1'b0;
        #3;
        check("rst_valid", bus.out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_data", bus.out_data_o, 0);
        check("rst_last", bus.out_last_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_snap(tbl[i]);

        // Reset in the middle of a snapshot.
        @(negedge clk);
        load_i = 1'b1;
        cfg_i  = seq;
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            load_i = 1'b0;
            check("rst_pre_data", bus.out_data_o, {54'd0, entry(seq, 0, k)});
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", bus.out_valid_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_data", bus.out_data_o, 0);
        check("rst_mid_col", bus.out_col_o, 0);
        check("rst_mid_row", bus.out_row_o, 0);
        check("rst_mid_last", bus.out_last_o, 0);
        check("rst_mid_done", done_o, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_valid", bus.out_valid_o, 0);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_valid", bus.out_valid_o, 0);
            check("post_rst_busy", busy_o, 0);
        end
        run_snap(tbl[0]);

        // load_i held high: back-to-back snapshots separated by one done cycle.
        @(negedge clk);
        load_i = 1'b1;
        cfg_i  = seq;
        bus.out_ready_i = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 20) load_i = 1'b0;
            check("b2b_valid", bus.out_valid_o, (k % 7) != 0);
            check("b2b_done", done_o, (k % 7) == 0);
            if ((k % 7) != 0) begin
                idx = (k % 7) - 1;
                check("b2b_row", bus.out_row_o, idx / COLS);
                check("b2b_col", bus.out_col_o, idx % COLS);
                check("b2b_data", bus.out_data_o, {54'd0, entry(seq, idx / COLS, idx % COLS)});
            end
        end
        @(negedge clk);
        check("b2b_idle", bus.out_valid_o, 0);

        // Randomized snapshots with random backpressure.
        for (int i = 0; i < 8; i++) begin
            rnd = {$urandom(), $urandom()};
            v.cfg          = rnd[CW-1:0];
            v.ready_mode   = 2;
            v.reload_beat  = $urandom_range(0, 1) ? int'($urandom_range(0, N-1)) : -1;
            v.change_after = 1'($urandom_range(0, 1));
            v.exp_cycles   = 0;
            run_snap(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_ctl_reader.md
FILTER_CTL_READER -- requirements
Module: filter_ctl_reader

Interface
REQ-001 The block SHALL have parameter ROWS, default 2, number of outer array rows.
REQ-002 The block SHALL have parameter COLS, default 3, number of entries per row.
REQ-003 The block SHALL have parameter OUT_W, default 32, output data width; OUT_W >= 10.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port load_i, input, 1, capture request for cfg_i.
REQ-007 The block SHALL have port cfg_i, input, ROWS*COLS*10, packed 2D array of filter_ctl_t, [ROWS-1:0][COLS-1:0].
REQ-008 The block SHALL have port busy_o, output, 1, high while a snapshot is being streamed.
REQ-009 The block SHALL have port out_valid_o, output, 1, entry available.
REQ-010 The block SHALL have port out_ready_i, input, 1, consumer accepts entry.
REQ-011 The block SHALL have port out_data_o, output, OUT_W, current entry zero-extended to OUT_W.
REQ-012 The block SHALL have port out_row_o, output, $clog2(ROWS) (min 1), row index of current entry.
REQ-013 The block SHALL have port out_col_o, output, $clog2(COLS) (min 1), column index of current entry.
REQ-014 The block SHALL have port out_last_o, output, 1, current entry is [ROWS-1][COLS-1].
REQ-015 The block SHALL have port done_o, output, 1, one-cycle pulse after final entry is accepted.

Function
REQ-016 filter_ctl_t SHALL be a 10-bit packed struct {mode[1:0], coef[7:0]}, mode in bits 9:8.
REQ-017 Entry [r][c] SHALL occupy cfg_i bits (r*COLS+c)*10 +: 10.
REQ-018 The FSM SHALL have states IDLE and STREAM.
REQ-019 In IDLE, load_i high SHALL capture cfg_i into a snapshot register, reset indices to [0][0], and enter STREAM.
REQ-020 out_valid_o SHALL rise on the cycle after load_i is sampled; latency is 1 cycle.
REQ-021 In STREAM, out_valid_o SHALL stay high and out_data_o/out_row_o/out_col_o/out_last_o SHALL stay stable until a handshake (out_valid_o & out_ready_i).
REQ-022 Order SHALL be row-major: col increments first, wraps to 0 at COLS-1 and increments row.
REQ-023 With out_ready_i held high, one entry SHALL transfer per cycle; ROWS*COLS cycles per snapshot.
REQ-024 The handshake on the out_last_o entry SHALL return the FSM to IDLE and drop out_valid_o the next cycle.
REQ-025 done_o SHALL pulse exactly one cycle, coincident with the first IDLE cycle after the last handshake.
REQ-026 load_i SHALL be ignored while in STREAM, including the cycle of the final handshake.
REQ-027 Changes on cfg_i after capture SHALL NOT affect the streamed data.
REQ-028 busy_o SHALL equal (state == STREAM).
REQ-029 out_data_o upper OUT_W-10 bits SHALL be zero.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, indices 0, snapshot 0, and all outputs 0, including mid-stream.
REQ-031 After rst_n deasserts, no entry of an aborted snapshot SHALL be presented; a new load_i is required.

Structure
REQ-032 filter_ctl_t, FILTER_CTL_W=10 and the state enum SHALL live in shared package filter_ctl_pkg.
REQ-033 The row/column index counter with wrap and last detection SHALL be one sub-module, filter_ctl_idx_cnt.
REQ-034 Entry selection SHALL use the package struct type on the snapshot, not hard-coded bit slices.

Verification
REQ-035 All entries 10'h3ff, ready high -> six beats out_data_o=32'd1023, rows/cols 00,01,02,10,11,12, last on sixth beat, done_o pulse on the 7th cycle after load.
REQ-036 Entry [r][c]=r*16+c+1 (entries 1,2,3,17,18,19), ready toggled 1/0 per cycle -> same values in order, each held stable while ready low.
REQ-037 load_i pulsed again at beat 3 with different cfg_i -> ignored; original six values delivered; busy_o high throughout.
REQ-038 rst_n asserted after beat 2, released 3 cycles later -> outputs 0 during reset, out_valid_o stays 0 until the next load_i.
REQ-039 load_i held high continuously, ready high -> back-to-back snapshots, each preceded by exactly one idle cycle carrying done_o.
REQ-040 cfg_i changed on the cycle after load -> streamed data equals the value captured at load.
